if_id_redirect_unit: RTL and testbench
======================================

// Module: if_id_redirect_unit
// PURPOSE
//  Consumer/steering end of the instr_fetch_unit interface. Captures instr_87/pc_87 each cycle into the IF/ID register.
//  Drives npc_87/sel_87 back to fetch for EX branch redirects, ID-stage early J/JAL jumps, and stalls (re-fetch same PC).
//  Sits between instr_fetch_unit and the decode stage. No branch delay slots: wrong-path fetches are squashed.
// PARAMETERS
//  INSTR_W   `INSTR_WIDTH (32)  instruction width
//  ADDR_W    `ADDR_WIDTH (32)   byte address width
//  CNT_W     16                 squash counter width
// PORTS
//  clk_87        in   1        clock, rising edge
//  rst_87        in   1        reset, asynchronous, active-low
//  instr_87      in   INSTR_W  fetched instruction, valid same cycle as pc_87
//  pc_87         in   ADDR_W   address of instr_87
//  npc_87        out  ADDR_W   redirect target to fetch (combinational)
//  sel_87        out  1        1: fetch loads npc_87 next edge; 0: pc+4
//  stall_87      in   1        hazard unit: hold ID contents
//  ex_redir_87   in   1        EX resolved taken branch/JR: flush
//  ex_target_87  in   ADDR_W   EX redirect target
//  id_instr_87   out  INSTR_W  IF/ID instruction
//  id_pc_87      out  ADDR_W   IF/ID pc
//  id_pc4_87     out  ADDR_W   id_pc_87 + 4 (JAL link value)
//  id_valid_87   out  1        IF/ID holds a real instruction
//  squash_cnt_87 out  CNT_W    saturating count of discarded fetches
// BEHAVIOUR
//  Reset (rst_87=0, async): id_instr/id_pc/id_valid/squash_cnt = 0, state=S_BUBBLE; sel_87=0, npc_87=0 while in reset.
//  Fetch contract: fetch PC register updates at posedge to (sel_87 ? npc_87 : pc_87+4).
//  jump_id = id_valid & !stall_87 & opcode(id_instr[31:26]) in {6'h02 J, 6'h03 JAL}.
//  jtarget = {id_pc4_87[ADDR_W-1:28], id_instr[25:0], 2'b00}.
//  Priority per cycle (highest first), combinational outputs / next-edge action:
//   1 ex_redir_87: npc=ex_target, sel=1; edge: id_valid<=0, squash+=1, state->S_BUBBLE (overrides stall).
//   2 stall_87:    npc=pc_87, sel=1 (re-fetch same PC); edge: IF/ID hold, state->S_STALL.
//   3 jump_id:     npc=jtarget, sel=1; edge: id_valid<=0 (discard pc_87 fetch), squash+=1, state->S_BUBBLE.
//   4 otherwise:   npc=0, sel=0; edge: id_instr<=instr_87, id_pc<=pc_87, id_valid<=1, state->S_RUN.
//  FSM: S_RUN (valid flowing), S_STALL (held), S_BUBBLE (ID empty). Transitions purely per priority table.
//   In S_BUBBLE id_valid=0, so jump_id cannot fire; stall_87 in S_BUBBLE still holds (bubble persists).
//  Latency: fetch -> ID 1 cycle; redirect request -> target in ID 2 cycles; each redirect costs 1 bubble.
//  squash_cnt: +1 per redirect edge, saturates at all-ones (no wrap).
//  id_pc4 = id_pc + 4, modulo 2^ADDR_W (wraps at top of address space).
//  Simultaneous: ex_redir with stall -> flush wins; ex_redir with jump_id -> EX target wins (older instr).
//  Reset mid-stall/mid-redirect: immediate async clear; first post-reset edge captures pc=0 fetch.
//  JR/JALR not decoded here (resolved in EX via ex_redir_87).
// STRUCTURE
//  mips_defs.vh: OPC_J=6'h02, OPC_JAL=6'h03, opcode field range, FSM state encodings (S_RUN/S_STALL/S_BUBBLE).
//  Sub-module: jump_decode (combinational opcode match + jtarget form). Counter and IF/ID regs inline.
// TESTING
//  1 reset release, fetch 0x0,0x4,0x8 -> id_pc 0x0,0x4 on successive edges, id_valid=1, sel=0.
//  2 ID holds J 0x08000010 at pc 0x100 -> sel=1, npc=0x00000040; next id_valid=0, squash=1; then id_pc=0x40.
//  3 stall_87=1 for 3 cycles at id_pc 0x20 -> npc=pc_87, sel=1, id_pc stays 0x20; resumes with no lost instr.
//  4 ex_redir_87=1, ex_target=0x200 with stall_87=1 -> sel=1, npc=0x200, id_valid=0 next; id_pc=0x200 after.
//  5 ex_redir and J in ID same cycle -> npc=ex_target; force squash_cnt near max -> saturates at 16'hFFFF.
//  6 assert rst_87 low while stalled -> outputs clear immediately (no clock), state S_BUBBLE.

Source files
------------

// File: rtl/if_id_redirect_unit_pkg.sv
// if_id_redirect_unit_pkg: shared widths, jump opcodes and IF/ID state encodings
package if_id_redirect_unit_pkg;
    localparam int INSTR_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int CNT_WIDTH = 16;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam logic [5:0] OPC_J = 6'h02;
    localparam logic [5:0] OPC_JAL = 6'h03;
    typedef enum logic [1:0] {S_RUN = 2'd0, S_STALL = 2'd1, S_BUBBLE = 2'd2} state_t;
    function automatic logic is_jump_opc(input logic [5:0] opc);
        return opc == OPC_J || opc == OPC_JAL;
    endfunction
endpackage

// File: rtl/if_id_redirect_unit_jump_decode.sv
// jump_decode: recognises J/JAL in ID and forms the pseudo-direct jump target
module jump_decode
    import if_id_redirect_unit_pkg::*;
#(
    parameter int INSTR_W = INSTR_WIDTH,
    parameter int ADDR_W = ADDR_WIDTH
) (
    input  logic [INSTR_W-1:0] instr,
    input  logic [ADDR_W-29:0] pc_hi,
    output logic               is_jump,
    output logic [ADDR_W-1:0]  target
);
    assign is_jump = is_jump_opc(instr[OPC_HI:OPC_LO]);
    assign target = {pc_hi, instr[25:0], 2'b00};
endmodule

// File: rtl/if_id_redirect_unit.sv
// if_id_redirect_unit: IF/ID register plus redirect steering (EX flush, ID jump, stall re-fetch) back to fetch
module if_id_redirect_unit
    import if_id_redirect_unit_pkg::*;
#(
    parameter int INSTR_W = INSTR_WIDTH,
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int CNT_W = CNT_WIDTH
) (
    input  logic               clk_87,
    input  logic               rst_87,
    input  logic [INSTR_W-1:0] instr_87,
    input  logic [ADDR_W-1:0]  pc_87,
    output logic [ADDR_W-1:0]  npc_87,
    output logic               sel_87,
    input  logic               stall_87,
    input  logic               ex_redir_87,
    input  logic [ADDR_W-1:0]  ex_target_87,
    output logic [INSTR_W-1:0] id_instr_87,
    output logic [ADDR_W-1:0]  id_pc_87,
    output logic [ADDR_W-1:0]  id_pc4_87,
    output logic               id_valid_87,
    output logic [CNT_W-1:0]   squash_cnt_87
);
    state_t state, state_n;
    logic is_jump, jump_id, capture;
    logic [ADDR_W-1:0] jtarget;

    assign id_pc4_87 = id_pc_87 + ADDR_W'(4);
    // S_STALL only ever holds a real instruction; a stalled bubble stays S_BUBBLE
    assign id_valid_87 = state != S_BUBBLE;

    jump_decode #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) u_jump_decode (
        .instr(id_instr_87),
        .pc_hi(id_pc4_87[ADDR_W-1:28]),
        .is_jump(is_jump),
        .target(jtarget)
    );

    assign jump_id = id_valid_87 & ~stall_87 & is_jump;
    assign capture = ~ex_redir_87 & ~stall_87 & ~jump_id;

    always_ff @(posedge clk_87 or negedge rst_87) begin
        if (!rst_87) state <= S_BUBBLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = ex_redir_87 ? S_BUBBLE :
                  stall_87 ? (state == S_BUBBLE ? S_BUBBLE : S_STALL) :
                  jump_id ? S_BUBBLE : S_RUN;
        sel_87 = rst_87 & (ex_redir_87 | stall_87 | jump_id);
        npc_87 = !rst_87 ? '0 :
                 ex_redir_87 ? ex_target_87 :
                 stall_87 ? pc_87 :
                 jump_id ? jtarget : '0;
    end

    always_ff @(posedge clk_87 or negedge rst_87) begin
        if (!rst_87) begin
            id_instr_87 <= '0;
            id_pc_87 <= '0;
            squash_cnt_87 <= '0;
        end else begin
            if ((ex_redir_87 | jump_id) && squash_cnt_87 != '1) squash_cnt_87 <= squash_cnt_87 + CNT_W'(1);
            if (capture) begin
                id_instr_87 <= instr_87;
                id_pc_87 <= pc_87;
            end
        end
    end
endmodule

// File: tb/tb_if_id_redirect_unit.sv
// tb_if_id_redirect_unit: directed scenarios against a bench-side fetch model and instruction ROM
module tb_if_id_redirect_unit;
    logic        clk = 0;
    logic        rst = 0;
    logic [31:0] instr, pc, npc, ex_target, id_instr, id_pc, id_pc4;
    logic        sel, stall, ex_redir, id_valid;
    logic [15:0] squash;
    int errors = 0, checks = 0;

    if_id_redirect_unit dut (
        .clk_87(clk), .rst_87(rst), .instr_87(instr), .pc_87(pc), .npc_87(npc), .sel_87(sel),
        .stall_87(stall), .ex_redir_87(ex_redir), .ex_target_87(ex_target), .id_instr_87(id_instr),
        .id_pc_87(id_pc), .id_pc4_87(id_pc4), .id_valid_87(id_valid), .squash_cnt_87(squash)
    );

    always #5 clk = ~clk;

    // fetch unit model: J 0x08000010 lives at 0x100, everything else is a non-jump
    always @(posedge clk or negedge rst) begin
        if (!rst) pc <= 0;
        else pc <= sel ? npc : pc + 4;
    end
    assign instr = (pc == 32'h100) ? 32'h0800_0010 : (32'h2000_0000 | {16'h0, pc[15:0]});

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_id_pc(input logic [31:0] a);
        for (int i = 0; i < 200 && id_pc !== a; i++) step();
        checks++;
        if (id_pc !== a) begin errors++; $display("FAIL wait_id_pc: got %h want %h (timeout)", id_pc, a); end
    endtask

    task automatic test_reset();
        stall = 0; ex_redir = 0; ex_target = 0;
        #12;
        checks++; if (id_valid !== 0 || id_pc !== 0 || squash !== 0) begin errors++; $display("FAIL reset_state: valid=%b pc=%h sq=%h want 0/0/0", id_valid, id_pc, squash); end
        checks++; if (sel !== 0 || npc !== 0) begin errors++; $display("FAIL reset_sel: sel=%b npc=%h want 0/0", sel, npc); end
        @(negedge clk); rst = 1;
        step();
        checks++; if (id_pc !== 0 || id_valid !== 1 || id_instr !== 32'h2000_0000) begin errors++; $display("FAIL first_capture: pc=%h v=%b i=%h want 0/1/20000000", id_pc, id_valid, id_instr); end
        checks++; if (sel !== 0 || id_pc4 !== 4) begin errors++; $display("FAIL first_sel: sel=%b pc4=%h want 0/4", sel, id_pc4); end
        step();
        checks++; if (id_pc !== 4 || id_valid !== 1) begin errors++; $display("FAIL second_capture: pc=%h v=%b want 4/1", id_pc, id_valid); end
    endtask

    task automatic test_id_jump();
        wait_id_pc(32'h100);
        checks++; if (sel !== 1 || npc !== 32'h40) begin errors++; $display("FAIL jump_redirect: sel=%b npc=%h want 1/40", sel, npc); end
        step();
        checks++; if (id_valid !== 0 || squash !== 1) begin errors++; $display("FAIL jump_bubble: v=%b sq=%h want 0/1", id_valid, squash); end
        checks++; if (sel !== 0) begin errors++; $display("FAIL jump_bubble_sel: sel=%b want 0", sel); end
        step();
        checks++; if (id_pc !== 32'h40 || id_valid !== 1) begin errors++; $display("FAIL jump_target: pc=%h v=%b want 40/1", id_pc, id_valid); end
    endtask

    task automatic test_stall();
        wait_id_pc(32'h48);
        stall = 1; #1;
        checks++; if (sel !== 1 || npc !== 32'h4C) begin errors++; $display("FAIL stall_refetch: sel=%b npc=%h want 1/4c", sel, npc); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (id_pc !== 32'h48 || id_valid !== 1 || pc !== 32'h4C) begin errors++; $display("FAIL stall_hold%0d: idpc=%h v=%b pc=%h want 48/1/4c", i, id_pc, id_valid, pc); end
        end
        stall = 0;
        step();
        checks++; if (id_pc !== 32'h4C || id_valid !== 1) begin errors++; $display("FAIL stall_resume: pc=%h v=%b want 4c/1", id_pc, id_valid); end
        step();
        checks++; if (id_pc !== 32'h50) begin errors++; $display("FAIL stall_next: pc=%h want 50", id_pc); end
    endtask

    task automatic test_ex_over_stall();
        stall = 1; ex_redir = 1; ex_target = 32'h200; #1;
        checks++; if (sel !== 1 || npc !== 32'h200) begin errors++; $display("FAIL ex_over_stall: sel=%b npc=%h want 1/200", sel, npc); end
        step();
        stall = 0; ex_redir = 0;
        checks++; if (id_valid !== 0 || squash !== 2) begin errors++; $display("FAIL ex_flush: v=%b sq=%h want 0/2", id_valid, squash); end
        step();
        checks++; if (id_pc !== 32'h200 || id_valid !== 1) begin errors++; $display("FAIL ex_target: pc=%h v=%b want 200/1", id_pc, id_valid); end
    endtask

    task automatic test_back_to_back();
        ex_redir = 1; ex_target = 32'h100;
        step();
        ex_redir = 0;
        step();
        checks++; if (id_pc !== 32'h100 || squash !== 3) begin errors++; $display("FAIL j_loaded: pc=%h sq=%h want 100/3", id_pc, squash); end
        ex_redir = 1; ex_target = 32'h300; #1;
        checks++; if (sel !== 1 || npc !== 32'h300) begin errors++; $display("FAIL ex_over_jump: sel=%b npc=%h want 1/300", sel, npc); end
        step();
        ex_redir = 0;
        checks++; if (squash !== 4 || id_valid !== 0) begin errors++; $display("FAIL single_squash: sq=%h v=%b want 4/0", squash, id_valid); end
        step();
        checks++; if (id_pc !== 32'h300) begin errors++; $display("FAIL ex_jump_target: pc=%h want 300", id_pc); end
        ex_redir = 1; ex_target = 32'h300;
        for (int i = 0; i < 65540; i++) step();
        checks++; if (squash !== 16'hFFFF) begin errors++; $display("FAIL squash_saturate: sq=%h want ffff", squash); end
        ex_redir = 0;
        step();
        checks++; if (squash !== 16'hFFFF || id_valid !== 1) begin errors++; $display("FAIL squash_hold: sq=%h v=%b want ffff/1", squash, id_valid); end
    endtask

    task automatic test_reset_mid_stall();
        stall = 1;
        step();
        checks++; if (id_valid !== 1) begin errors++; $display("FAIL pre_reset_valid: v=%b want 1", id_valid); end
        rst = 0; #1;
        checks++; if (id_valid !== 0 || id_pc !== 0 || id_instr !== 0 || squash !== 0) begin errors++; $display("FAIL async_clear: v=%b pc=%h i=%h sq=%h want 0", id_valid, id_pc, id_instr, squash); end
        checks++; if (sel !== 0 || npc !== 0) begin errors++; $display("FAIL reset_outputs: sel=%b npc=%h want 0/0", sel, npc); end
        @(negedge clk); rst = 1; stall = 0;
        step();
        checks++; if (id_pc !== 0 || id_valid !== 1) begin errors++; $display("FAIL post_reset_fetch: pc=%h v=%b want 0/1", id_pc, id_valid); end
    endtask

    initial begin
        test_reset();
        test_id_jump();
        test_stall();
        test_ex_over_stall();
        test_back_to_back();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
